// File: rtl/game_screen_ctrl_pkg.sv
// Shared screen-path constants: state encodings, key codes and complete-screen select codes.
package game_screen_ctrl_pkg;

   typedef enum logic [2:0] {
      SCR_MENU     = 3'd0,
      SCR_PLAY     = 3'd1,
      SCR_COMPLETE = 3'd2,
      SCR_OVER     = 3'd3,
      SCR_ALLCLR   = 3'd4
   } scr_e;

   localparam logic [4:0] KEY_SEL  = 5'h1d;
   localparam logic [4:0] KEY_MOVE = 5'h1e;

   localparam logic [1:0] SEL_RESTART = 2'b00;
   localparam logic [1:0] SEL_MENU    = 2'b01;
   localparam logic [1:0] SEL_NEXT    = 2'b10;
   localparam logic [1:0] SEL_NONE    = 2'b11;

endpackage

// File: rtl/game_screen_ctrl_blank_timer.sv
// Loadable down-counter with a busy flag; saturates at zero.
// Used for the inter-screen blank interval and the optional stage timer.
module game_screen_ctrl_blank_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         busy
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority; otherwise count down while enabled and non-zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/game_screen_ctrl.sv
// Screen sequencer for the game display path: game state FSM, stage index,
// per-screen reset pulse, blank interval between screens and rgb mux.
// Optional macro STAGE_TIMER_EN adds a per-stage play-time limit.
module game_screen_ctrl
   import game_screen_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES     = 3,
   parameter int unsigned BLANK_CYCLES   = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_pulse,
   input  logic [1:0] menu_sel,
   input  logic       stage_clear,
   input  logic       stage_fail,
   input  logic [1:0] complete_sel,
   input  logic [2:0] rgb_menu,
   input  logic [2:0] rgb_play,
   input  logic [2:0] rgb_complete,
   input  logic [2:0] rgb_over,
   output logic [2:0] rgb,
   output logic [2:0] screen,
   output logic [1:0] stage,
   output logic       scr_rst,
   output logic       blank
);

   localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

   scr_e       screen_q, screen_d;
   logic [1:0] stage_q, stage_d;
   logic       scr_rst_q, scr_rst_d;
   logic       go;
   logic       timeout;

   // Blank interval counter, loaded on every transition.
   game_screen_ctrl_blank_timer #(.W(BLANK_W)) u_blank (
      .clk      (clk),
      .rst      (rst),
      .en       (1'b1),
      .load     (go),
      .load_val (BLANK_W'(BLANK_CYCLES)),
      .busy     (blank)
   );

`ifdef STAGE_TIMER_EN
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic tmr_busy;

   // Play-time limit: reloaded on PLAY entry, runs only in unblanked PLAY.
   game_screen_ctrl_blank_timer #(.W(TMR_W)) u_stage_tmr (
      .clk      (clk),
      .rst      (rst),
      .en       ((screen_q == SCR_PLAY) && !blank),
      .load     (go && (screen_d == SCR_PLAY)),
      .load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
      .busy     (tmr_busy)
   );

   assign timeout = (screen_q == SCR_PLAY) && !blank && !tmr_busy;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // Next-state: events are only honoured outside the blank interval.
   always_comb begin
      screen_d  = screen_q;
      stage_d   = stage_q;
      go        = 1'b0;
      if (!blank) begin
         case (screen_q)
            SCR_MENU: begin
               if ((menu_sel != SEL_NONE) && (32'(menu_sel) < NUM_STAGES)) begin
                  screen_d = SCR_PLAY;
                  stage_d  = menu_sel;
                  go       = 1'b1;
               end
            end
            SCR_PLAY: begin
               if (stage_clear) begin
                  screen_d = SCR_COMPLETE;
                  go       = 1'b1;
               end else if (stage_fail || timeout) begin
                  screen_d = SCR_OVER;
                  go       = 1'b1;
               end
            end
            SCR_COMPLETE: begin
               case (complete_sel)
                  SEL_RESTART: begin
                     screen_d = SCR_PLAY;
                     go       = 1'b1;
                  end
                  SEL_MENU: begin
                     screen_d = SCR_MENU;
                     stage_d  = 2'd0;
                     go       = 1'b1;
                  end
                  SEL_NEXT: begin
                     if (32'(stage_q) == NUM_STAGES - 1) begin
                        screen_d = SCR_ALLCLR;
                     end else begin
                        screen_d = SCR_PLAY;
                        stage_d  = stage_q + 2'd1;
                     end
                     go = 1'b1;
                  end
                  default: ;
               endcase
            end
            SCR_OVER, SCR_ALLCLR: begin
               if (key_pulse == KEY_SEL) begin
                  screen_d = SCR_MENU;
                  stage_d  = 2'd0;
                  go       = 1'b1;
               end
            end
            default: begin
               screen_d = SCR_MENU;
               stage_d  = 2'd0;
            end
         endcase
      end
      scr_rst_d = go;
   end

   // State, stage and screen-reset registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         screen_q  <= SCR_MENU;
         stage_q   <= 2'd0;
         scr_rst_q <= 1'b0;
      end else begin
         screen_q  <= screen_d;
         stage_q   <= stage_d;
         scr_rst_q <= scr_rst_d;
      end
   end

   // Pixel mux from registered state; black while blanking.
   always_comb begin
      rgb = 3'b000;
      if (!blank) begin
         case (screen_q)
            SCR_MENU:             rgb = rgb_menu;
            SCR_PLAY:             rgb = rgb_play;
            SCR_COMPLETE:         rgb = rgb_complete;
            SCR_OVER, SCR_ALLCLR: rgb = rgb_over;
            default:              rgb = 3'b000;
         endcase
      end
   end

   assign screen  = screen_q;
   assign stage   = stage_q;
   assign scr_rst = scr_rst_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl with BLANK_CYCLES=4, NUM_STAGES=3, TIMEOUT_CYCLES=20.
module tb_game_screen_ctrl;
   import game_screen_ctrl_pkg::*;

   localparam int unsigned NB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] key_pulse;
   logic [1:0] menu_sel;
   logic       stage_clear;
   logic       stage_fail;
   logic [1:0] complete_sel;
   logic [2:0] rgb_menu, rgb_play, rgb_complete, rgb_over;
   logic [2:0] rgb;
   logic [2:0] screen;
   logic [1:0] stage;
   logic       scr_rst;
   logic       blank;

   int n_tests = 0;
   int n_fail  = 0;

   game_screen_ctrl #(
      .NUM_STAGES     (3),
      .BLANK_CYCLES   (NB),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_pulse    (key_pulse),
      .menu_sel     (menu_sel),
      .stage_clear  (stage_clear),
      .stage_fail   (stage_fail),
      .complete_sel (complete_sel),
      .rgb_menu     (rgb_menu),
      .rgb_play     (rgb_play),
      .rgb_complete (rgb_complete),
      .rgb_over     (rgb_over),
      .rgb          (rgb),
      .screen       (screen),
      .stage        (stage),
      .scr_rst      (scr_rst),
      .blank        (blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      key_pulse    = 5'h00;
      menu_sel     = SEL_NONE;
      stage_clear  = 1'b0;
      stage_fail   = 1'b0;
      complete_sel = SEL_NONE;
   endtask

   // Checks the cycle right after a transition event.
   task automatic chk_entry(input string tag, input scr_e exp_scr, input logic [1:0] exp_stg);
      chk({tag, ".screen"}, 32'(screen), 32'(exp_scr));
      chk({tag, ".stage"},  32'(stage),  32'(exp_stg));
      chk({tag, ".scr_rst"}, 32'(scr_rst), 32'd1);
      chk({tag, ".blank"},  32'(blank),  32'd1);
      chk({tag, ".rgb_blk"}, 32'(rgb),   32'd0);
   endtask

   // Runs out the rest of the blank interval (entry cycle already consumed).
   task automatic end_blank(input string tag, input logic [2:0] exp_rgb);
      step();
      chk({tag, ".scr_rst_drop"}, 32'(scr_rst), 32'd0);
      repeat (NB - 2) step();
      chk({tag, ".blank_last"}, 32'(blank), 32'd1);
      step();
      chk({tag, ".blank_end"}, 32'(blank), 32'd0);
      chk({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
   endtask

   initial begin
      rgb_menu     = 3'b001;
      rgb_play     = 3'b010;
      rgb_complete = 3'b011;
      rgb_over     = 3'b100;
      idle_inputs();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst.screen",  32'(screen),  32'(SCR_MENU));
      chk("rst.stage",   32'(stage),   32'd0);
      chk("rst.scr_rst", 32'(scr_rst), 32'd0);
      chk("rst.blank",   32'(blank),   32'd0);
      chk("rst.rgb",     32'(rgb),     32'(3'b001));

      // Stray play event in MENU is ignored
      stage_clear = 1'b1;
      step();
      idle_inputs();
      chk("menu_stray.screen", 32'(screen), 32'(SCR_MENU));
      chk("menu_stray.scr_rst", 32'(scr_rst), 32'd0);

      // 1: menu_sel=01 -> PLAY stage 1
      menu_sel = 2'b01;
      step();
      idle_inputs();
      chk_entry("t1", SCR_PLAY, 2'd1);
      end_blank("t1", 3'b010);

      // 2: clear and fail together -> COMPLETE
      stage_clear = 1'b1;
      stage_fail  = 1'b1;
      step();
      idle_inputs();
      chk_entry("t2_clr", SCR_COMPLETE, 2'd1);

      // 3: restart during blank is ignored
      complete_sel = SEL_RESTART;
      step();
      idle_inputs();
      chk("t3_blank_ign.screen", 32'(screen), 32'(SCR_COMPLETE));
      chk("t3_blank_ign.scr_rst", 32'(scr_rst), 32'd0);
      repeat (NB - 2) step();
      chk("t3.blank_last", 32'(blank), 32'd1);
      step();
      chk("t3.blank_end", 32'(blank), 32'd0);
      chk("t3.rgb", 32'(rgb), 32'(3'b011));
      complete_sel = SEL_RESTART;
      step();
      idle_inputs();
      chk_entry("t3_restart", SCR_PLAY, 2'd1);
      end_blank("t3_restart", 3'b010);

      // 2 cont.: clear, next -> PLAY stage 2
      stage_clear = 1'b1;
      step();
      idle_inputs();
      chk_entry("t2_clr2", SCR_COMPLETE, 2'd1);
      end_blank("t2_clr2", 3'b011);
      complete_sel = SEL_NEXT;
      step();
      idle_inputs();
      chk_entry("t2_next", SCR_PLAY, 2'd2);
      end_blank("t2_next", 3'b010);

      // Last stage: clear, next -> ALLCLR, stage stays 2
      stage_clear = 1'b1;
      step();
      idle_inputs();
      chk_entry("t2_clr3", SCR_COMPLETE, 2'd2);
      end_blank("t2_clr3", 3'b011);
      complete_sel = SEL_NEXT;
      step();
      idle_inputs();
      chk_entry("t2_allclr", SCR_ALLCLR, 2'd2);
      end_blank("t2_allclr", 3'b100);
      key_pulse = KEY_MOVE;
      step();
      idle_inputs();
      chk("t2_allclr_move.screen", 32'(screen), 32'(SCR_ALLCLR));
      key_pulse = KEY_SEL;
      step();
      idle_inputs();
      chk_entry("t2_menu", SCR_MENU, 2'd0);
      end_blank("t2_menu", 3'b001);

      // 4: PLAY stage 2, stray complete code ignored, fail -> OVER
      menu_sel = 2'b10;
      step();
      idle_inputs();
      chk_entry("t4_play", SCR_PLAY, 2'd2);
      end_blank("t4_play", 3'b010);
      complete_sel = SEL_RESTART;
      key_pulse    = KEY_SEL;
      step();
      idle_inputs();
      chk("t4_stray.screen", 32'(screen), 32'(SCR_PLAY));
      stage_fail = 1'b1;
      step();
      idle_inputs();
      chk_entry("t4_over", SCR_OVER, 2'd2);
      end_blank("t4_over", 3'b100);
      key_pulse = KEY_MOVE;
      step();
      idle_inputs();
      chk("t4_move.screen", 32'(screen), 32'(SCR_OVER));
      chk("t4_move.scr_rst", 32'(scr_rst), 32'd0);
      key_pulse = KEY_SEL;
      step();
      idle_inputs();
      chk_entry("t4_menu", SCR_MENU, 2'd0);
      end_blank("t4_menu", 3'b001);

      // COMPLETE -> MENU via select code 01
      menu_sel = 2'b00;
      step();
      idle_inputs();
      chk_entry("sm_play", SCR_PLAY, 2'd0);
      end_blank("sm_play", 3'b010);
      stage_clear = 1'b1;
      step();
      idle_inputs();
      chk_entry("sm_cmp", SCR_COMPLETE, 2'd0);
      end_blank("sm_cmp", 3'b011);
      complete_sel = SEL_MENU;
      step();
      idle_inputs();
      chk_entry("sm_menu", SCR_MENU, 2'd0);
      end_blank("sm_menu", 3'b001);

      // 6: idle in PLAY
      menu_sel = 2'b00;
      step();
      idle_inputs();
      chk_entry("t6_play", SCR_PLAY, 2'd0);
      end_blank("t6_play", 3'b010);
`ifdef STAGE_TIMER_EN
      repeat (19) step();
      chk("t6_pre_timeout.screen", 32'(screen), 32'(SCR_PLAY));
      step();
      chk_entry("t6_timeout", SCR_OVER, 2'd0);
      end_blank("t6_timeout", 3'b100);
`else
      repeat (100) step();
      chk("t6_no_timer.screen", 32'(screen), 32'(SCR_PLAY));
      stage_fail = 1'b1;
      step();
      idle_inputs();
      chk_entry("t6_fail", SCR_OVER, 2'd0);
      end_blank("t6_fail", 3'b100);
`endif
      key_pulse = KEY_SEL;
      step();
      idle_inputs();
      chk_entry("t6_menu", SCR_MENU, 2'd0);
      end_blank("t6_menu", 3'b001);

      // 5: async reset mid-blank in PLAY
      menu_sel = 2'b01;
      step();
      idle_inputs();
      chk_entry("t5_play", SCR_PLAY, 2'd1);
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst.screen",  32'(screen),  32'(SCR_MENU));
      chk("t5_rst.stage",   32'(stage),   32'd0);
      chk("t5_rst.blank",   32'(blank),   32'd0);
      chk("t5_rst.scr_rst", 32'(scr_rst), 32'd0);
      chk("t5_rst.rgb",     32'(rgb),     32'(3'b001));
      step();
      rst = 1'b0;
      step();
      chk("t5_post.screen", 32'(screen), 32'(SCR_MENU));
      chk("t5_post.scr_rst", 32'(scr_rst), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
